// File: rtl/pipeline_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline stall/flush sequencer.
//   REGBITS / regbits_t : register index width used for hazard compares
//   ST_* / pipe_state_t : sequencer state encoding (RUN, DWAIT, DRAIN, HALTED)
//   ctl_t               : bundle of pipeline control outputs
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

    localparam int REGBITS = 5;
    typedef logic [REGBITS-1:0] regbits_t;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DWAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    typedef enum logic [1:0] {
        RUN    = ST_RUN,
        DWAIT  = ST_DWAIT,
        DRAIN  = ST_DRAIN,
        HALTED = ST_HALTED
    } pipe_state_t;

    typedef struct packed {
        logic pc_en;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic flush_ifid;
        logic flush_idex;
        logic flush_exmem;
        logic flush_memwb;
        logic dflush_req;
    } ctl_t;

    // Everything off: no enables, no flushes, no writeback request.
    function automatic ctl_t ctl_idle();
        ctl_t c;
        c = '0;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard.sv
// ---------------------------------------------------------------------------
// hazard_unit
// Load-use hazard detect. Purely combinational so the forwarding logic can
// reuse the same compare.
//   memRead_EX : EX-stage instruction is a load
//   rt_EX      : load destination register in EX
//   rs_ID      : ID-stage source 1
//   rt_ID      : ID-stage source 2
//   lduse      : ID instruction consumes the EX load result next cycle
// ---------------------------------------------------------------------------
module hazard_unit
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_W = REGBITS
) (
    input  logic             memRead_EX,
    input  logic [REG_W-1:0] rt_EX,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    output logic             lduse
);

    // Register 0 is hardwired to zero, so a load into it never creates a hazard.
    always_comb begin
        lduse = memRead_EX & (rt_EX != '0) & ((rt_EX == rs_ID) | (rt_EX == rt_ID));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage pipeline. Drives the enable/flush
// pair of each pipeline latch and the PC enable, runs the halt-drain
// sequence with the dcache writeback handshake, and counts stall cycles.
//   CLK, RST           : clock, synchronous active-high reset
//   ihit, dhit         : icache hit, dcache hit/ack
//   dREN_MEM, dWEN_MEM : MEM-stage load / store
//   memRead_EX, rt_EX,
//   rs_ID, rt_ID       : load-use hazard inputs
//   taken_MEM          : branch/jump resolved taken in MEM
//   halt_MEM           : halt instruction in MEM
//   dflush_done        : dcache writeback complete
//   pc_en, en_*, flush_* : PC and latch controls (flush wins over enable)
//   dflush_req         : dcache writeback request
//   halt               : sticky halted flag
//   stall_cnt          : saturating count of pc_en=0 cycles outside HALTED
//   state              : current FSM state
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | normal issue; priority dmiss > halt > taken > lduse > imiss
// DWAIT  | pipeline frozen until dcache acknowledges the MEM access
// DRAIN  | halt committing to WB, then dcache writeback handshake
// HALTED | everything off, halt=1; only reset leaves
// ---------------------------------------------------------------------------
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = REGBITS
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dREN_MEM,
    input  logic             dWEN_MEM,
    input  logic             memRead_EX,
    input  logic [REG_W-1:0] rt_EX,
    input  logic [REG_W-1:0] rs_ID,
    input  logic [REG_W-1:0] rt_ID,
    input  logic             taken_MEM,
    input  logic             halt_MEM,
    input  logic             dflush_done,
    output logic             pc_en,
    output logic             en_IFID,
    output logic             en_IDEX,
    output logic             en_EXMEM,
    output logic             en_MEMWB,
    output logic             flush_IFID,
    output logic             flush_IDEX,
    output logic             flush_EXMEM,
    output logic             flush_MEMWB,
    output logic             dflush_req,
    output logic             halt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    pipe_state_t      state_q;
    pipe_state_t      state_n;
    logic             drain_first_q;
    logic             halt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             lduse;
    logic             dmiss;
    ctl_t             ctl;
    ctl_t             ctl_out;

    hazard_unit #(
        .REG_W (REG_W)
    ) u_hazard (
        .memRead_EX (memRead_EX),
        .rt_EX      (rt_EX),
        .rs_ID      (rs_ID),
        .rt_ID      (rt_ID),
        .lduse      (lduse)
    );

    assign dmiss = (dREN_MEM | dWEN_MEM) & ~dhit;

    // RUN-state priority with the dcache miss already excluded. Flushed
    // latches keep their enable high; the latch gives flush precedence.
    function automatic ctl_t run_rules(input logic h, input logic tk,
                                       input logic lu, input logic ih);
        ctl_t c;
        c = ctl_idle();
        if (h || tk) begin
            c.pc_en       = tk & ~h;
            c.en_ifid     = 1'b1;
            c.en_idex     = 1'b1;
            c.en_exmem    = 1'b1;
            c.en_memwb    = 1'b1;
            c.flush_ifid  = 1'b1;
            c.flush_idex  = 1'b1;
            c.flush_exmem = 1'b1;
        end else if (lu || !ih) begin
            // Hold PC and IF/ID, push a bubble into ID/EX, let older work drain.
            c.en_idex    = 1'b1;
            c.en_exmem   = 1'b1;
            c.en_memwb   = 1'b1;
            c.flush_idex = 1'b1;
        end else begin
            c.pc_en    = 1'b1;
            c.en_ifid  = 1'b1;
            c.en_idex  = 1'b1;
            c.en_exmem = 1'b1;
            c.en_memwb = 1'b1;
        end
        return c;
    endfunction

    always_comb begin
        ctl     = ctl_idle();
        state_n = state_q;
        unique case (state_q)
            RUN: begin
                if (dmiss) begin
                    state_n = DWAIT;
                end else begin
                    ctl = run_rules(halt_MEM, taken_MEM, lduse, ihit);
                    if (halt_MEM) state_n = DRAIN;
                end
            end
            DWAIT: begin
                // A branch or halt parked in MEM is only acted on once the
                // access completes.
                if (dhit) begin
                    ctl     = run_rules(halt_MEM, taken_MEM, lduse, ihit);
                    state_n = halt_MEM ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                ctl.en_memwb   = drain_first_q;
                ctl.dflush_req = ~drain_first_q;
                if (dflush_done && !drain_first_q) state_n = HALTED;
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    // Reset forces bubbles everywhere without waiting for a clock edge.
    always_comb begin
        ctl_out = ctl;
        if (RST) begin
            ctl_out             = ctl_idle();
            ctl_out.flush_ifid  = 1'b1;
            ctl_out.flush_idex  = 1'b1;
            ctl_out.flush_exmem = 1'b1;
            ctl_out.flush_memwb = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= RUN;
            drain_first_q <= 1'b1;
            halt_q        <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            state_q       <= state_n;
            // Set on every non-DRAIN cycle so the first DRAIN cycle sees it high.
            drain_first_q <= (state_q != DRAIN);
            if (state_q == DRAIN && state_n == HALTED) begin
                halt_q <= 1'b1;
            end
            if (state_q != HALTED && !ctl.pc_en && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
        end
    end

    assign pc_en       = ctl_out.pc_en;
    assign en_IFID     = ctl_out.en_ifid;
    assign en_IDEX     = ctl_out.en_idex;
    assign en_EXMEM    = ctl_out.en_exmem;
    assign en_MEMWB    = ctl_out.en_memwb;
    assign flush_IFID  = ctl_out.flush_ifid;
    assign flush_IDEX  = ctl_out.flush_idex;
    assign flush_EXMEM = ctl_out.flush_exmem;
    assign flush_MEMWB = ctl_out.flush_memwb;
    assign dflush_req  = ctl_out.dflush_req;
    assign halt        = halt_q;
    assign stall_cnt   = stall_cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, dREN_MEM, dWEN_MEM, memRead_EX;
    logic [4:0] rt_EX, rs_ID, rt_ID;
    logic       taken_MEM, halt_MEM, dflush_done;

    logic        pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB;
    logic        flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB;
    logic        dflush_req, halt;
    logic [15:0] stall_cnt;
    logic [1:0]  state;

    logic        pc_en4, en_IFID4, en_IDEX4, en_EXMEM4, en_MEMWB4;
    logic        flush_IFID4, flush_IDEX4, flush_EXMEM4, flush_MEMWB4;
    logic        dflush_req4, halt4;
    logic [3:0]  stall_cnt4;
    logic [1:0]  state4;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.CNT_W(16), .REG_W(5)) u_dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dREN_MEM(dREN_MEM), .dWEN_MEM(dWEN_MEM), .memRead_EX(memRead_EX),
        .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .taken_MEM(taken_MEM), .halt_MEM(halt_MEM), .dflush_done(dflush_done),
        .pc_en(pc_en), .en_IFID(en_IFID), .en_IDEX(en_IDEX),
        .en_EXMEM(en_EXMEM), .en_MEMWB(en_MEMWB),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .flush_EXMEM(flush_EXMEM), .flush_MEMWB(flush_MEMWB),
        .dflush_req(dflush_req), .halt(halt), .stall_cnt(stall_cnt), .state(state)
    );

    pipeline_ctrl #(.CNT_W(4), .REG_W(5)) u_dut4 (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dREN_MEM(dREN_MEM), .dWEN_MEM(dWEN_MEM), .memRead_EX(memRead_EX),
        .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .taken_MEM(taken_MEM), .halt_MEM(halt_MEM), .dflush_done(dflush_done),
        .pc_en(pc_en4), .en_IFID(en_IFID4), .en_IDEX(en_IDEX4),
        .en_EXMEM(en_EXMEM4), .en_MEMWB(en_MEMWB4),
        .flush_IFID(flush_IFID4), .flush_IDEX(flush_IDEX4),
        .flush_EXMEM(flush_EXMEM4), .flush_MEMWB(flush_MEMWB4),
        .dflush_req(dflush_req4), .halt(halt4), .stall_cnt(stall_cnt4), .state(state4)
    );

    // {pc_en, en IFID/IDEX/EXMEM/MEMWB, flush IFID/IDEX/EXMEM/MEMWB, dflush_req}
    wire [9:0] ctl = {pc_en, en_IFID, en_IDEX, en_EXMEM, en_MEMWB,
                      flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB, dflush_req};

    localparam logic [9:0] M_ALL    = {1'b1, 4'b1111, 4'b1111, 1'b1};
    localparam logic [9:0] M_NOIDEX = {1'b1, 4'b1011, 4'b1111, 1'b1};
    localparam logic [9:0] M_FLUSH3 = {1'b1, 4'b0001, 4'b1111, 1'b1};

    localparam logic [9:0] E_RESET  = {1'b0, 4'b0000, 4'b1111, 1'b0};
    localparam logic [9:0] E_NORMAL = {1'b1, 4'b1111, 4'b0000, 1'b0};
    localparam logic [9:0] E_FREEZE = {1'b0, 4'b0000, 4'b0000, 1'b0};
    localparam logic [9:0] E_STALL  = {1'b0, 4'b0011, 4'b0100, 1'b0};
    localparam logic [9:0] E_BRANCH = {1'b1, 4'b0001, 4'b1110, 1'b0};
    localparam logic [9:0] E_HALTM  = {1'b0, 4'b0001, 4'b1110, 1'b0};
    localparam logic [9:0] E_DRAIN1 = {1'b0, 4'b0001, 4'b0000, 1'b0};
    localparam logic [9:0] E_DRAINN = {1'b0, 4'b0000, 4'b0000, 1'b1};

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; dREN_MEM = 1'b0; dWEN_MEM = 1'b0;
        memRead_EX = 1'b0; rt_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
        taken_MEM = 1'b0; halt_MEM = 1'b0; dflush_done = 1'b0;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_inputs();
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        ihit = 1'b1; taken_MEM = 1'b1; dREN_MEM = 1'b1; halt_MEM = 1'b1;
        memRead_EX = 1'b1; rt_EX = 5'd3; rs_ID = 5'd3;
        @(negedge CLK);
        total_cnt++;
        if (ctl !== E_RESET) $display("FAIL reset_ctl_c0: got %b expected %b", ctl, E_RESET);
        else pass_cnt++;
        tick();
        @(negedge CLK);
        total_cnt++;
        if (ctl !== E_RESET) $display("FAIL reset_ctl_c1: got %b expected %b", ctl, E_RESET);
        else pass_cnt++;
        total_cnt++;
        if ({state, halt, stall_cnt} !== {2'd0, 1'b0, 16'd0})
            $display("FAIL reset_regs: got state=%0d halt=%b cnt=%0d expected 0/0/0", state, halt, stall_cnt);
        else pass_cnt++;
        tick();
        RST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        total_cnt++;
        if (ctl !== E_NORMAL) $display("FAIL reset_release_ctl: got %b expected %b", ctl, E_NORMAL);
        else pass_cnt++;
        total_cnt++;
        if ({state, stall_cnt} !== {2'd0, 16'd0})
            $display("FAIL reset_release_regs: got state=%0d cnt=%0d expected 0/0", state, stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_dcache_miss();
        do_reset();
        dREN_MEM = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        total_cnt++;
        if ({state, ctl} !== {2'd0, E_FREEZE})
            $display("FAIL dmiss_run: got state=%0d ctl=%b expected 0 %b", state, ctl, E_FREEZE);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            tick();
            @(negedge CLK);
            total_cnt++;
            if ({state, ctl} !== {2'd1, E_FREEZE})
                $display("FAIL dmiss_wait%0d: got state=%0d ctl=%b expected 1 %b", i, state, ctl, E_FREEZE);
            else pass_cnt++;
        end
        tick();
        dhit = 1'b1;
        @(negedge CLK);
        total_cnt++;
        if ({state, ctl} !== {2'd1, E_NORMAL})
            $display("FAIL dmiss_hit: got state=%0d ctl=%b expected 1 %b", state, ctl, E_NORMAL);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd3) $display("FAIL dmiss_cnt: got %0d expected 3", stall_cnt);
        else pass_cnt++;
        tick();
        idle_inputs();
        @(negedge CLK);
        total_cnt++;
        if ({state, ctl, stall_cnt} !== {2'd0, E_NORMAL, 16'd3})
            $display("FAIL dmiss_after: got state=%0d ctl=%b cnt=%0d expected 0 %b 3", state, ctl, stall_cnt, E_NORMAL);
        else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_reset();
        memRead_EX = 1'b1; rt_EX = 5'd5; rs_ID = 5'd5; rt_ID = 5'd1;
        @(negedge CLK);
        total_cnt++;
        if ((ctl & M_NOIDEX) !== (E_STALL & M_NOIDEX)) $display("FAIL lduse_rs: got %b expected %b", ctl, E_STALL);
        else pass_cnt++;
        tick();
        memRead_EX = 1'b0;
        @(negedge CLK);
        total_cnt++;
        if (ctl !== E_NORMAL) $display("FAIL lduse_clear: got %b expected %b", ctl, E_NORMAL);
        else pass_cnt++;
        tick();
        memRead_EX = 1'b1; rt_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
        @(negedge CLK);
        total_cnt++;
        if (ctl !== E_NORMAL) $display("FAIL lduse_r0: got %b expected %b", ctl, E_NORMAL);
        else pass_cnt++;
        tick();
        rt_EX = 5'd9; rs_ID = 5'd2; rt_ID = 5'd9;
        @(negedge CLK);
        total_cnt++;
        if ((ctl & M_NOIDEX) !== (E_STALL & M_NOIDEX)) $display("FAIL lduse_rt: got %b expected %b", ctl, E_STALL);
        else pass_cnt++;
        tick();
        memRead_EX = 1'b0;
        @(negedge CLK);
        total_cnt++;
        if (ctl !== E_NORMAL) $display("FAIL lduse_noload: got %b expected %b", ctl, E_NORMAL);
        else pass_cnt++;
        tick();
        ihit = 1'b0;
        @(negedge CLK);
        total_cnt++;
        if ((ctl & M_NOIDEX) !== (E_STALL & M_NOIDEX)) $display("FAIL imiss: got %b expected %b", ctl, E_STALL);
        else pass_cnt++;
        tick();
        idle_inputs();
        @(negedge CLK);
        total_cnt++;
        if (stall_cnt !== 16'd3) $display("FAIL lduse_cnt: got %0d expected 3", stall_cnt);
        else pass_cnt++;
    endtask

    task automatic test_branch_priority();
        do_reset();
        taken_MEM = 1'b1; ihit = 1'b0; memRead_EX = 1'b1; rt_EX = 5'd5; rs_ID = 5'd5;
        @(negedge CLK);
        total_cnt++;
        if ((ctl & M_FLUSH3) !== (E_BRANCH & M_FLUSH3)) $display("FAIL branch_prio: got %b expected %b", ctl, E_BRANCH);
        else pass_cnt++;
        tick();
        dREN_MEM = 1'b1; dhit = 1'b0;
        @(negedge CLK);
        total_cnt++;
        if ({state, ctl} !== {2'd0, E_FREEZE})
            $display("FAIL branch_dmiss: got state=%0d ctl=%b expected 0 %b", state, ctl, E_FREEZE);
        else pass_cnt++;
        tick();
        @(negedge CLK);
        total_cnt++;
        if ({state, ctl} !== {2'd1, E_FREEZE})
            $display("FAIL branch_dwait: got state=%0d ctl=%b expected 1 %b", state, ctl, E_FREEZE);
        else pass_cnt++;
        tick();
        dhit = 1'b1;
        @(negedge CLK);
        total_cnt++;
        if (state !== 2'd1 || (ctl & M_FLUSH3) !== (E_BRANCH & M_FLUSH3))
            $display("FAIL branch_dhit: got state=%0d ctl=%b expected 1 %b", state, ctl, E_BRANCH);
        else pass_cnt++;
        tick();
        idle_inputs();
        @(negedge CLK);
        total_cnt++;
        if ({state, ctl, stall_cnt} !== {2'd0, E_NORMAL, 16'd2})
            $display("FAIL branch_after: got state=%0d ctl=%b cnt=%0d expected 0 %b 2", state, ctl, stall_cnt, E_NORMAL);
        else pass_cnt++;
    endtask

    task automatic test_halt();
        do_reset();
        halt_MEM = 1'b1;
        @(negedge CLK);
        total_cnt++;
        if (state !== 2'd0 || (ctl & M_FLUSH3) !== (E_HALTM & M_FLUSH3))
            $display("FAIL halt_mem: got state=%0d ctl=%b expected 0 %b", state, ctl, E_HALTM);
        else pass_cnt++;
        tick();
        halt_MEM = 1'b0;
        @(negedge CLK);
        total_cnt++;
        if ({state, ctl} !== {2'd2, E_DRAIN1})
            $display("FAIL drain_first: got state=%0d ctl=%b expected 2 %b", state, ctl, E_DRAIN1);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge CLK);
            total_cnt++;
            if ({state, ctl, halt} !== {2'd2, E_DRAINN, 1'b0})
                $display("FAIL drain_req%0d: got state=%0d ctl=%b halt=%b expected 2 %b 0", i, state, ctl, halt, E_DRAINN);
            else pass_cnt++;
        end
        tick();
        dflush_done = 1'b1;
        @(negedge CLK);
        total_cnt++;
        if ({state, ctl, halt} !== {2'd2, E_DRAINN, 1'b0})
            $display("FAIL drain_done: got state=%0d ctl=%b halt=%b expected 2 %b 0", state, ctl, halt, E_DRAINN);
        else pass_cnt++;
        tick();
        dflush_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ihit = i[0];
            @(negedge CLK);
            total_cnt++;
            if ({state, ctl, halt} !== {2'd3, E_FREEZE, 1'b1})
                $display("FAIL halted%0d: got state=%0d ctl=%b halt=%b expected 3 %b 1", i, state, ctl, halt, E_FREEZE);
            else pass_cnt++;
            tick();
        end
        total_cnt++;
        if (stall_cnt !== 16'd7) $display("FAIL halt_cnt: got %0d expected 7", stall_cnt);
        else pass_cnt++;
        RST = 1'b1;
        @(negedge CLK);
        total_cnt++;
        if (ctl !== E_RESET) $display("FAIL halted_rst_ctl: got %b expected %b", ctl, E_RESET);
        else pass_cnt++;
        tick();
        RST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        total_cnt++;
        if ({state, halt, ctl} !== {2'd0, 1'b0, E_NORMAL})
            $display("FAIL halted_rst_exit: got state=%0d halt=%b ctl=%b expected 0 0 %b", state, halt, ctl, E_NORMAL);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        halt_MEM = 1'b1;
        tick();
        halt_MEM = 1'b0;
        tick();
        tick();
        @(negedge CLK);
        total_cnt++;
        if ({state, ctl} !== {2'd2, E_DRAINN})
            $display("FAIL middrain_pre: got state=%0d ctl=%b expected 2 %b", state, ctl, E_DRAINN);
        else pass_cnt++;
        RST = 1'b1;
        #1;
        total_cnt++;
        if (ctl !== E_RESET) $display("FAIL middrain_rst_ctl: got %b expected %b", ctl, E_RESET);
        else pass_cnt++;
        tick();
        RST = 1'b0;
        dflush_done = 1'b1;
        @(negedge CLK);
        total_cnt++;
        if ({state, halt, ctl} !== {2'd0, 1'b0, E_NORMAL})
            $display("FAIL middrain_exit: got state=%0d halt=%b ctl=%b expected 0 0 %b", state, halt, ctl, E_NORMAL);
        else pass_cnt++;
        tick();
        dflush_done = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        ihit = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                total_cnt++;
                if (stall_cnt4 !== 4'd14) $display("FAIL sat_pre: got %0d expected 14", stall_cnt4);
                else pass_cnt++;
            end
        end
        @(negedge CLK);
        total_cnt++;
        if (stall_cnt4 !== 4'd15) $display("FAIL sat_hold: got %0d expected 15", stall_cnt4);
        else pass_cnt++;
        total_cnt++;
        if (stall_cnt !== 16'd20) $display("FAIL sat_wide: got %0d expected 20", stall_cnt);
        else pass_cnt++;
        idle_inputs();
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        test_reset();
        test_dcache_miss();
        test_load_use();
        test_branch_priority();
        test_halt();
        test_reset_mid_drain();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It generates the enable/flush pair for each pipeline latch (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable, from cache hit signals, load-use hazards, taken branches/jumps and halt. It also owns the halt-drain sequence, including the dcache writeback handshake, and a saturating stall-cycle counter for performance measurement.

Parameters:
CNT_W, 16, width of stall-cycle counter (saturating)
REG_W, 5, register index width

Ports:
CLK  in  1  clock; all state updates on rising edge
RST  in  1  synchronous reset, active-high
ihit  in  1  icache hit for current fetch
dhit  in  1  dcache hit/ack for MEM-stage access
dREN_MEM  in  1  MEM-stage load
dWEN_MEM  in  1  MEM-stage store
memRead_EX  in  1  EX-stage instruction is a load
rt_EX  in  REG_W  load destination in EX
rs_ID  in  REG_W  ID source 1
rt_ID  in  REG_W  ID source 2
taken_MEM  in  1  branch/jump resolved taken, in EX/MEM latch
halt_MEM  in  1  halt reached MEM stage
dflush_done  in  1  dcache writeback complete
pc_en  out  1  PC register load enable
en_IFID, en_IDEX, en_EXMEM, en_MEMWB  out  1 each  latch enables
flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB  out  1 each  latch bubble-insert
dflush_req  out  1  request dcache writeback
halt  out  1  CPU halted (registered, sticky)
stall_cnt  out  CNT_W  cycles with pc_en=0 outside HALTED
state  out  2  current FSM state (debug)

Behaviour:
- Interface: single clock CLK; RST synchronous active-high. While RST=1, outputs are forced combinationally: all en_*=0, all flush_*=1, pc_en=0, dflush_req=0. On the edge with RST=1: state<=RUN, halt<=0, stall_cnt<=0. Reset mid-drain or while HALTED returns to RUN, with no dflush_req pulse.
- States (2-bit encoding): RUN=0, DWAIT=1, DRAIN=2, HALTED=3.
- dmiss = (dREN_MEM|dWEN_MEM) & ~dhit. lduse = memRead_EX & (rt_EX!=0) & ((rt_EX==rs_ID)|(rt_EX==rt_ID)).
- RUN outputs use this priority:
  1. dmiss: all en_*=0, pc_en=0, no flush. Next state DWAIT.
  2. halt_MEM: flush_IFID=flush_IDEX=flush_EXMEM=1, en_MEMWB=1, pc_en=0. Next state DRAIN.
  3. taken_MEM: pc_en=1; flush_IFID=flush_IDEX=flush_EXMEM=1; en_MEMWB=1. This applies even if ihit=0.
  4. lduse: pc_en=0, en_IFID=0, flush_IDEX=1, en_EXMEM=en_MEMWB=1.
  5. ~ihit: pc_en=0, en_IFID=0, flush_IDEX=1, downstream enabled.
  6. Otherwise: all en_*=1, pc_en=1, no flush.
- Flush dominates enable when both are 1 (latch semantics).
- DWAIT:
  - While ~dhit: freeze everything.
  - On dhit: evaluate RUN rules 2–6 in the same cycle (dmiss is now false) and go to RUN.
  - A branch or halt held in MEM is therefore acted on only after the access completes. Zero-cycle hits never enter DWAIT.
- DRAIN:
  - pc_en=0; all en_*=0 except en_MEMWB=1 on the first DRAIN cycle only, so the halt commits to WB. Tracked by a 1-bit first flag.
  - dflush_req=1 from the second DRAIN cycle until dflush_done.
  - dflush_done sampled 1 with dflush_req=1: go to HALTED, and set halt<=1 on that edge.
- HALTED: all en_*=0, flush_*=0, pc_en=0, dflush_req=0, halt=1. Only RST exits.
- stall_cnt: increments on each edge where RST=0, state!=HALTED and pc_en=0. Saturates at 2^CNT_W-1; no wrap.
- The only combinational paths are inputs→en/flush/pc_en. halt, state and stall_cnt are registered.

Decomposition:
- Shared cpu package: typedef enum logic[1:0] pipe_state_t {RUN, DWAIT, DRAIN, HALTED} and a regbits_t-width constant reused for REG_W.
- Hazard detection (lduse compare) as sub-module hazard_unit: purely combinational, reusable by the forwarding logic.
- The FSM, output decode and counter stay in pipeline_ctrl.

Test Plan:
- Reset: RST=1 for 2 cycles with arbitrary inputs → all flush_*=1, en_*=0, pc_en=0; after release with ihit=1 and no hazards → state=RUN, all en_*=1, pc_en=1, stall_cnt=0.
- Dcache miss: dREN_MEM=1, dhit=0 for 3 cycles then 1 → state=DWAIT for 3 cycles, all en_*=0, stall_cnt=3; in the dhit cycle all en_*=1, then RUN.
- Load-use: memRead_EX=1, rt_EX=5, rs_ID=5 → pc_en=0, en_IFID=0, flush_IDEX=1 for one cycle. Repeat with rt_EX=0 → no stall.
- Branch and priority:
  - taken_MEM=1 with ihit=0 and lduse true → pc_en=1, flush_IFID/IDEX/EXMEM=1, en_MEMWB=1.
  - Same inputs plus dmiss → full freeze, and branch flush is applied in the cycle dhit rises.
- Halt sequence: halt_MEM=1 → DRAIN; en_MEMWB=1 on first DRAIN cycle only; dflush_req=1 from cycle 2; dflush_done after 4 cycles → halt=1 on the next edge, state=HALTED; hold 10 cycles with ihit toggling → outputs unchanged. Assert RST mid-DRAIN → RUN with halt=0.
- Counter saturation: CNT_W=4, hold ihit=0 for 20 cycles → stall_cnt stops at 15.
